// File: rtl/mux3_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux3_rr_arbiter
// Description : Round-robin arbiter for one shared 3-input mux/resource with
//               hold-until-done grants and a hold timer that preempts owners.
// Revision    : 1.0 - initial release
// ============================================================================
module mux3_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic [2:0] req,
  input  logic       done,
  output logic [2:0] gnt,
  output logic [1:0] select_a,
  output logic       busy,
  output logic       timeout
);

  localparam logic [0:0]       c_idle   = 1'b0;
  localparam logic [0:0]       c_busy   = 1'b1;
  localparam bit               c_tmo_en = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] c_max    = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] c_last   = CNT_W'(MAX_HOLD - 1);

  logic [0:0]       r_state;
  logic [2:0]       r_gnt;
  logic [1:0]       r_sel;
  logic [1:0]       r_ptr;
  logic [CNT_W-1:0] r_cnt;

  logic             w_owner_req;
  logic             w_release;
  logic             w_tmo;
  logic [2:0]       w_cand;
  logic             w_any;
  logic [1:0]       w_p1;
  logic [1:0]       w_p2;
  logic [1:0]       w_win;

  // Withdrawal and done are the same release; the timer only fires on a
  // still-requesting owner that has not signalled done.
  assign w_owner_req = |(req & r_gnt);
  assign w_release   = (r_state == c_busy) && (done || !w_owner_req);
  assign w_tmo       = c_tmo_en && (r_state == c_busy) && (r_cnt == c_last) &&
                       !done && w_owner_req;

  // While busy the owner is excluded, so it is re-granted only via IDLE.
  always_comb begin
    w_cand = (r_state == c_busy) ? (req & ~r_gnt) : req;
    w_any  = |w_cand;
    w_p1   = (r_ptr == 2'd2) ? 2'd0 : r_ptr + 2'd1;
    w_p2   = (r_ptr == 2'd0) ? 2'd2 : r_ptr - 2'd1;
    w_win  = r_ptr;
    if (w_cand[w_p1]) begin
      w_win = w_p1;
    end else if (w_cand[w_p2]) begin
      w_win = w_p2;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= c_idle;
      r_gnt   <= 3'b000;
      r_sel   <= 2'd0;
      r_ptr   <= 2'd2;
      r_cnt   <= '0;
    end else if ((r_state == c_idle) || w_release || w_tmo) begin
      if (w_any) begin
        r_state <= c_busy;
        r_gnt   <= 3'b001 << w_win;
        r_sel   <= w_win;
        r_ptr   <= w_win;
        r_cnt   <= '0;
      end else begin
        r_state <= c_idle;
        r_gnt   <= 3'b000;
      end
    end else if (r_cnt != c_max) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign gnt      = r_gnt;
  assign select_a = r_sel;
  assign busy     = |r_gnt;
  assign timeout  = w_tmo;

endmodule
`default_nettype wire

// File: tb/tb_mux3_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux3_rr_arbiter
// Description : Directed scoreboard bench for mux3_rr_arbiter (MAX_HOLD = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux3_rr_arbiter;

  logic       clk;
  logic       arst_n;
  logic [2:0] req;
  logic       done;
  logic [2:0] gnt;
  logic [1:0] select_a;
  logic       busy;
  logic       timeout;

  typedef struct packed {
    logic [2:0] gnt;
    logic [1:0] sel;
    logic       tmo;
  } exp_t;

  exp_t q_exp[$];
  int   n_cmp = 0;
  int   n_err = 0;

  mux3_rr_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .select_a (select_a),
    .busy     (busy),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Called at a falling edge: drive inputs, check the same-cycle timeout,
  // then check the registered outputs after the next rising edge.
  task automatic step(input string tag, input logic [2:0] r, input logic d,
                      input logic [2:0] eg, input logic [1:0] es, input logic et);
    exp_t e;
    req  = r;
    done = d;
    q_exp.push_back('{gnt: eg, sel: es, tmo: et});
    #1;
    chk({tag, ".timeout"}, {3'b000, timeout}, {3'b000, q_exp[0].tmo});
    @(posedge clk);
    @(negedge clk);
    e = q_exp.pop_front();
    chk({tag, ".gnt"},  {1'b0, gnt},      {1'b0, e.gnt});
    chk({tag, ".sel"},  {2'b00, select_a}, {2'b00, e.sel});
    chk({tag, ".busy"}, {3'b000, busy},   {3'b000, |e.gnt});
  endtask

  task automatic do_reset(input string tag);
    arst_n = 1'b0;
    req    = 3'b000;
    done   = 1'b0;
    #1;
    chk({tag, ".gnt"},     {1'b0, gnt},       4'h0);
    chk({tag, ".sel"},     {2'b00, select_a}, 4'h0);
    chk({tag, ".busy"},    {3'b000, busy},    4'h0);
    chk({tag, ".timeout"}, {3'b000, timeout}, 4'h0);
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  initial begin
    arst_n = 1'b0;
    req    = 3'b000;
    done   = 1'b0;
    @(negedge clk);
    do_reset("rst0");

    // Single request, grant after one edge, release on done
    step("t1.grant",   3'b001, 1'b0, 3'b001, 2'd0, 1'b0);
    step("t1.done",    3'b001, 1'b1, 3'b000, 2'd0, 1'b0);
    step("t1.idle",    3'b000, 1'b0, 3'b000, 2'd0, 1'b0);
    step("t1.idledn",  3'b000, 1'b1, 3'b000, 2'd0, 1'b0);

    // All request, done every second cycle: 0,1,2,0,1 back to back
    do_reset("rst2");
    step("t2.g0",   3'b111, 1'b0, 3'b001, 2'd0, 1'b0);
    step("t2.h0",   3'b111, 1'b0, 3'b001, 2'd0, 1'b0);
    step("t2.g1",   3'b111, 1'b1, 3'b010, 2'd1, 1'b0);
    step("t2.h1",   3'b111, 1'b0, 3'b010, 2'd1, 1'b0);
    step("t2.g2",   3'b111, 1'b1, 3'b100, 2'd2, 1'b0);
    step("t2.h2",   3'b111, 1'b0, 3'b100, 2'd2, 1'b0);
    step("t2.g0b",  3'b111, 1'b1, 3'b001, 2'd0, 1'b0);
    step("t2.h0b",  3'b111, 1'b0, 3'b001, 2'd0, 1'b0);
    step("t2.g1b",  3'b111, 1'b1, 3'b010, 2'd1, 1'b0);
    step("t2.end",  3'b000, 1'b1, 3'b000, 2'd1, 1'b0);

    // Owner 1 never finishes: revoked in its 8th cycle, handed to req0
    do_reset("rst3");
    step("t3.grant", 3'b010, 1'b0, 3'b010, 2'd1, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      step($sformatf("t3.hold%0d", k), (k >= 5) ? 3'b011 : 3'b010, 1'b0,
           3'b010, 2'd1, 1'b0);
    end
    step("t3.revoke", 3'b011, 1'b0, 3'b001, 2'd0, 1'b1);
    step("t3.after",  3'b011, 1'b0, 3'b001, 2'd0, 1'b0);

    // Owner 0 reaches its 8th cycle with done: done wins, no timeout
    for (int k = 2; k <= 7; k++) begin
      step($sformatf("t4.hold%0d", k), 3'b011, 1'b0, 3'b001, 2'd0, 1'b0);
    end
    step("t4.donewin", 3'b011, 1'b1, 3'b010, 2'd1, 1'b0);

    // Done and withdrawal together are one release; then owner 2 withdraws
    step("t5.dualrel",  3'b101, 1'b1, 3'b100, 2'd2, 1'b0);
    step("t5.hold2",    3'b101, 1'b0, 3'b100, 2'd2, 1'b0);
    step("t5.withdraw", 3'b001, 1'b0, 3'b001, 2'd0, 1'b0);
    step("t5.idle",     3'b001, 1'b1, 3'b000, 2'd0, 1'b0);

    // Asynchronous reset in the middle of a grant to requester 1
    step("t6.grant", 3'b010, 1'b0, 3'b010, 2'd1, 1'b0);
    step("t6.hold",  3'b010, 1'b0, 3'b010, 2'd1, 1'b0);
    #2;
    do_reset("t6.rst");
    step("t6.first",  3'b111, 1'b0, 3'b001, 2'd0, 1'b0);
    step("t6.next",   3'b110, 1'b1, 3'b010, 2'd1, 1'b0);
    step("t6.end",    3'b000, 1'b1, 3'b000, 2'd1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
